// File: rtl/wb_timer.sv
// wb_timer: Wishbone-attached down-counting timer with prescaler,
// auto-reload and a level interrupt.
`timescale 1ns/1ps
module wb_timer #(
    parameter int unsigned PRESCALE_W = 8,
    parameter logic [31:0] RST_LOAD   = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_arst_n,
    input  logic        i_wb_we,
    input  logic [3:0]  i_wb_sel,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_irq
);

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_LOAD   = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    logic                  r_ack;
    logic [31:0]           r_dat;
    logic                  r_en;
    logic                  r_auto;
    logic                  r_irq_en;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] r_pcnt;
    logic [31:0]           r_load;
    logic [31:0]           r_count;
    logic                  r_expired;

    logic                  w_req;
    logic                  w_wr;
    logic                  w_wr_ctrl;
    logic                  w_wr_load;
    logic                  w_wr_count;
    logic                  w_wr_status;
    logic [31:0]           w_mask;
    logic [31:0]           w_ctrl_rd;
    logic [31:0]           w_rd_mux;
    logic                  w_tick;
    logic                  w_expire;
    logic                  w_en_nx;
    logic                  w_auto_nx;
    logic                  w_irq_en_nx;
    logic [PRESCALE_W-1:0] w_pre_nx;
    logic [PRESCALE_W-1:0] w_pcnt_nx;
    logic [31:0]           w_load_nx;
    logic [31:0]           w_count_nx;
    logic                  w_exp_nx;
    logic                  w_unused;

    assign w_unused = ^{i_wb_adr[31:4], i_wb_adr[1:0]};

    assign w_req  = i_wb_cyc & i_wb_stb & ~r_ack;
    // A write with no byte selected is acked but touches no state.
    assign w_wr   = w_req & i_wb_we & (|i_wb_sel);
    assign w_mask = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}},
                     {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};

    assign w_wr_ctrl   = w_wr & (i_wb_adr[3:2] == A_CTRL);
    assign w_wr_load   = w_wr & (i_wb_adr[3:2] == A_LOAD);
    assign w_wr_count  = w_wr & (i_wb_adr[3:2] == A_COUNT);
    assign w_wr_status = w_wr & (i_wb_adr[3:2] == A_STATUS);

    assign w_tick   = r_en & (r_pcnt == r_prescale);
    assign w_expire = w_tick & (r_count == 32'd0);

    assign o_irq    = r_expired & r_irq_en;
    assign o_wb_ack = r_ack;
    assign o_wb_dat = r_dat;

    // Assemble CTRL read view and select the read data word.
    always_comb begin
        w_ctrl_rd = 32'd0;
        w_ctrl_rd[0] = r_en;
        w_ctrl_rd[1] = r_auto;
        w_ctrl_rd[2] = r_irq_en;
        w_ctrl_rd[8 +: PRESCALE_W] = r_prescale;
        case (i_wb_adr[3:2])
            A_CTRL:  w_rd_mux = w_ctrl_rd;
            A_LOAD:  w_rd_mux = r_load;
            A_COUNT: w_rd_mux = r_count;
            default: w_rd_mux = {31'd0, r_expired};
        endcase
    end

    // Next-state of timer registers; bus writes override timer events.
    always_comb begin
        w_en_nx     = r_en;
        w_auto_nx   = r_auto;
        w_irq_en_nx = r_irq_en;
        w_pre_nx    = r_prescale;
        w_load_nx   = r_load;
        w_count_nx  = r_count;
        w_exp_nx    = r_expired;
        w_pcnt_nx   = r_pcnt;

        if (w_expire && !r_auto) w_en_nx = 1'b0;
        if (w_wr_ctrl) begin
            if (i_wb_sel[0]) begin
                w_en_nx     = i_wb_dat[0];
                w_auto_nx   = i_wb_dat[1];
                w_irq_en_nx = i_wb_dat[2];
            end
            for (int b = 0; b < PRESCALE_W; b++) begin
                if (w_mask[8+b]) w_pre_nx[b] = i_wb_dat[8+b];
            end
        end

        if (w_wr_load)
            w_load_nx = (r_load & ~w_mask) | (i_wb_dat & w_mask);

        if (w_wr_count)
            w_count_nx = (r_count & ~w_mask) | (i_wb_dat & w_mask);
        else if (w_tick) begin
            if (r_count != 32'd0) w_count_nx = r_count - 32'd1;
            else if (r_auto)      w_count_nx = r_load;
            else                  w_count_nx = 32'd0;
        end

        if (w_expire)
            w_exp_nx = 1'b1;
        else if (w_wr_status && i_wb_sel[0] && i_wb_dat[0])
            w_exp_nx = 1'b0;

        // Counter is parked at 0 whenever EN is, or will be, low.
        if (!r_en || !w_en_nx || w_tick) w_pcnt_nx = '0;
        else                              w_pcnt_nx = r_pcnt + 1'b1;
    end

    // Bus response: one-cycle ack pulse, read data captured on reads.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_ack <= 1'b0;
            r_dat <= 32'd0;
        end else begin
            r_ack <= i_wb_cyc & i_wb_stb & ~r_ack;
            if (w_req && !i_wb_we) r_dat <= w_rd_mux;
        end
    end

    // Timer state registers.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_en       <= 1'b0;
            r_auto     <= 1'b0;
            r_irq_en   <= 1'b0;
            r_prescale <= '0;
            r_pcnt     <= '0;
            r_load     <= RST_LOAD;
            r_count    <= 32'd0;
            r_expired  <= 1'b0;
        end else begin
            r_en       <= w_en_nx;
            r_auto     <= w_auto_nx;
            r_irq_en   <= w_irq_en_nx;
            r_prescale <= w_pre_nx;
            r_pcnt     <= w_pcnt_nx;
            r_load     <= w_load_nx;
            r_count    <= w_count_nx;
            r_expired  <= w_exp_nx;
        end
    end

endmodule

// File: tb/tb_wb_timer.sv
// tb_wb_timer: directed vector table plus hand-written
// multi-cycle sequences for wb_timer.
`timescale 1ns/1ps
module tb_wb_timer;

    localparam logic [31:0] A_CTRL   = 32'h0;
    localparam logic [31:0] A_LOAD   = 32'h4;
    localparam logic [31:0] A_COUNT  = 32'h8;
    localparam logic [31:0] A_STATUS = 32'hC;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0;
    logic [31:0] wdat = 32'h0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic [31:0] rdat;
    logic        ack;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    wb_timer dut (
        .i_clk    (clk),
        .i_arst_n (arst_n),
        .i_wb_we  (we),
        .i_wb_sel (sel),
        .i_wb_adr (adr),
        .i_wb_dat (wdat),
        .i_wb_cyc (cyc),
        .i_wb_stb (stb),
        .o_wb_dat (rdat),
        .o_wb_ack (ack),
        .o_irq    (irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One transfer: drive at negedge, wait for ack, then one idle edge.
    task automatic bus(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output int lat);
        @(negedge clk);
        we = w; adr = a; wdat = d; sel = s; cyc = 1'b1; stb = 1'b1;
        lat = 0;
        while (lat < 8) begin
            @(posedge clk); #1;
            lat++;
            if (ack) break;
        end
        rd = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input string nm, input logic [31:0] a,
                      input logic [31:0] d);
        logic [31:0] r;
        int l;
        bus(1'b1, a, d, 4'hF, r, l);
        chk({nm, "_lat"}, 32'(l), 32'd1);
    endtask

    task automatic rd(input string nm, input logic [31:0] a,
                      input logic [31:0] exp);
        logic [31:0] r;
        int l;
        bus(1'b0, a, 32'h0, 4'hF, r, l);
        chk({nm, "_lat"}, 32'(l), 32'd1);
        chk(nm, r, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int l;
        int k;
        int nack;
        logic [31:0] e;

        tbl[0]  = '{1'b0, A_CTRL,   32'h0,         4'hF, 32'h0};
        tbl[1]  = '{1'b0, A_LOAD,   32'h0,         4'hF, 32'h0};
        tbl[2]  = '{1'b0, A_COUNT,  32'h0,         4'hF, 32'h0};
        tbl[3]  = '{1'b0, A_STATUS, 32'h0,         4'hF, 32'h0};
        tbl[4]  = '{1'b1, A_LOAD,   32'h5,         4'hF, 32'h0};
        tbl[5]  = '{1'b0, A_LOAD,   32'h0,         4'hF, 32'h5};
        tbl[6]  = '{1'b0, 32'hFFFF_F004, 32'h0,    4'hF, 32'h5};
        tbl[7]  = '{1'b1, A_LOAD,   32'h0,         4'hF, 32'h0};
        tbl[8]  = '{1'b1, A_LOAD,   32'hAABB_CCDD, 4'h5, 32'h0};
        tbl[9]  = '{1'b0, A_LOAD,   32'h0,         4'hF, 32'h00BB_00DD};
        tbl[10] = '{1'b1, A_LOAD,   32'hFFFF_FFFF, 4'h0, 32'h0};
        tbl[11] = '{1'b0, A_LOAD,   32'h0,         4'hF, 32'h00BB_00DD};
        tbl[12] = '{1'b1, A_CTRL,   32'hFFFF_FFF8, 4'hF, 32'h0};
        tbl[13] = '{1'b0, A_CTRL,   32'h0,         4'hF, 32'h0000_FF00};
        tbl[14] = '{1'b1, A_CTRL,   32'h0,         4'hF, 32'h0};
        tbl[15] = '{1'b1, A_COUNT,  32'h1234,      4'hF, 32'h0};
        tbl[16] = '{1'b1, A_LOAD,   32'h7,         4'hF, 32'h0};
        tbl[17] = '{1'b0, A_COUNT,  32'h0,         4'hF, 32'h1234};
        tbl[18] = '{1'b1, A_STATUS, 32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[19] = '{1'b0, A_STATUS, 32'h0,         4'hF, 32'h0};
        tbl[20] = '{1'b1, A_COUNT,  32'h0,         4'hF, 32'h0};

        // Reset state, observed while reset is held.
        #12;
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_dat", rdat, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        arst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            bus(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, r, l);
            chk($sformatf("v%0d_lat", i), 32'(l), 32'd1);
            if (!tbl[i].we)
                chk($sformatf("v%0d_rd", i), r, tbl[i].exp);
        end

        // Strobe held three edges: ack 0,1,0,1.
        @(negedge clk);
        adr = A_LOAD; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        chk("hold_ack0", {31'd0, ack}, 32'd0);
        @(posedge clk); #1;
        chk("hold_ack1", {31'd0, ack}, 32'd1);
        chk("hold_dat", rdat, 32'h7);
        @(posedge clk); #1;
        chk("hold_ack2", {31'd0, ack}, 32'd0);
        @(posedge clk); #1;
        chk("hold_ack3", {31'd0, ack}, 32'd1);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;

        // One-shot with interrupt.
        wr("os_load", A_LOAD, 32'd3);
        wr("os_cnt", A_COUNT, 32'd3);
        wr("os_ctrl", A_CTRL, 32'h0000_0005);
        k = 1;
        chk("os_irq_early", {31'd0, irq}, 32'd0);
        while (!irq && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("os_irq_cycle", 32'(k), 32'd4);
        rd("os_status", A_STATUS, 32'd1);
        rd("os_ctrl_rb", A_CTRL, 32'h0000_0004);
        rd("os_count_rb", A_COUNT, 32'd0);
        wr("os_clr", A_STATUS, 32'd1);
        chk("os_irq_clr", {31'd0, irq}, 32'd0);
        wr("os_off", A_CTRL, 32'd0);

        // Auto-reload with prescale 2, COUNT polled by a held read.
        wr("ar_load", A_LOAD, 32'd1);
        wr("ar_cnt", A_COUNT, 32'd1);
        wr("ar_ctrl", A_CTRL, 32'h0000_0203);
        adr = A_COUNT; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        nack = 0;
        for (int j = 2; j <= 13; j++) begin
            @(posedge clk); #1;
            chk($sformatf("ar_irq%0d", j), {31'd0, irq}, 32'd0);
            if (ack) begin
                nack++;
                e = (((j - 1) / 3) % 2 == 0) ? 32'd1 : 32'd0;
                chk($sformatf("ar_cnt%0d", j), rdat, e);
            end
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        chk("ar_nack", 32'(nack), 32'd6);
        rd("ar_status", A_STATUS, 32'd1);
        wr("ar_off", A_CTRL, 32'd0);
        wr("ar_clr", A_STATUS, 32'd1);

        // STATUS clear on the expiry edge: set wins.
        wr("ca_cnt", A_COUNT, 32'd1);
        wr("ca_ctrl", A_CTRL, 32'h0000_0001);
        wr("ca_clr", A_STATUS, 32'd1);
        rd("ca_status", A_STATUS, 32'd1);
        wr("ca_clr2", A_STATUS, 32'd1);
        rd("ca_status2", A_STATUS, 32'd0);

        // COUNT write on a tick edge: bus wins, then next tick decrements.
        wr("cb_cnt", A_COUNT, 32'd100);
        wr("cb_ctrl", A_CTRL, 32'h0000_0201);
        @(posedge clk);
        wr("cb_w9", A_COUNT, 32'd9);
        rd("cb_r9", A_COUNT, 32'd9);
        rd("cb_r8", A_COUNT, 32'd8);
        wr("cb_off", A_CTRL, 32'd0);

        // Reset during a CTRL write before it is acked.
        @(negedge clk);
        adr = A_CTRL; wdat = 32'd1; sel = 4'hF; we = 1'b1;
        cyc = 1'b1; stb = 1'b1;
        #2 arst_n = 1'b0;
        #1 chk("rm_ack_async", {31'd0, ack}, 32'd0);
        @(posedge clk); #1;
        chk("rm_ack_edge", {31'd0, ack}, 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        rd("rm_ctrl", A_CTRL, 32'd0);
        rd("rm_load", A_LOAD, 32'd0);
        rd("rm_count", A_COUNT, 32'd0);

        // Request pending across reset release is acked on first edge.
        @(negedge clk);
        arst_n = 1'b0;
        adr = A_LOAD; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk); #1;
        chk("rr_ack", {31'd0, ack}, 32'd1);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        chk("rr_ack_drop", {31'd0, ack}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
